// File: rtl/ac97_frame_serializer.sv
`default_nettype none
// =============================================================================
// ac97_frame_serializer - AC'97 controller output link: 256-bit frames (tag,
// command slots 1/2, PCM slots 3/4) on SYNC/SDATA_OUT plus per-frame strobe.
// Revision: 1.0
// =============================================================================
module ac97_frame_serializer (
  input  logic        I_BITCLK,
  input  logic        I_RESET_N,
  input  logic [19:0] I_LEFT_SAMPLE,
  input  logic [19:0] I_RIGHT_SAMPLE,
  input  logic        I_CMD_VALID,
  input  logic        I_CMD_READ,
  input  logic [6:0]  I_CMD_ADDR,
  input  logic [15:0] I_CMD_DATA,
  output logic        O_CMD_READY,
  output logic        O_SYNC,
  output logic        O_SDATA_OUT,
  output logic        O_STROBE
);

  localparam logic [7:0] C_CNT_RESET  = 8'd254;
  localparam logic [7:0] C_B_LATCH    = 8'd255;
  localparam logic [7:0] C_B_STROBE   = 8'd252;
  localparam logic [7:0] C_B_SYNC_END = 8'd14;
  localparam logic [7:0] C_B_DATA_END = 8'd95;
  localparam logic [6:0] C_DATA_MSB   = 7'd95;

  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_next;
  logic        w_latch;
  logic        w_accept;
  logic        w_pending_next;

  logic        r_pending;
  logic        r_pend_read;
  logic [6:0]  r_pend_addr;
  logic [15:0] r_pend_data;

  logic [19:0] r_frm_left;
  logic [19:0] r_frm_right;
  logic        r_frm_cmd;
  logic        r_frm_read;
  logic [6:0]  r_frm_addr;
  logic [15:0] r_frm_data;

  logic [15:0] w_tag;
  logic [19:0] w_slot1;
  logic [19:0] w_slot2;
  logic [95:0] w_frame;
  logic [6:0]  w_idx;
  logic        w_bit;
  logic        w_sync;
  logic        w_frm_write;

  assign w_cnt_next = r_cnt + 8'd1;
  assign w_latch    = (w_cnt_next == C_B_LATCH);
  assign w_accept   = I_CMD_VALID & ~r_pending;

  // A same-edge accept wins over the latch clear: the latch only consumed the old (empty) entry.
  assign w_pending_next = w_accept ? 1'b1 : (w_latch ? 1'b0 : r_pending);

  always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_cnt       <= C_CNT_RESET;
      r_pending   <= 1'b0;
      r_pend_read <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_pending <= w_pending_next;
      if (w_accept) begin
        r_pend_read <= I_CMD_READ;
        r_pend_addr <= I_CMD_ADDR;
        r_pend_data <= I_CMD_DATA;
      end
    end
  end

  always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      r_frm_left  <= '0;
      r_frm_right <= '0;
      r_frm_cmd   <= 1'b0;
      r_frm_read  <= 1'b0;
      r_frm_addr  <= '0;
      r_frm_data  <= '0;
    end else if (w_latch) begin
      r_frm_left  <= I_LEFT_SAMPLE;
      r_frm_right <= I_RIGHT_SAMPLE;
      r_frm_cmd   <= r_pending;
      r_frm_read  <= r_pend_read;
      r_frm_addr  <= r_pend_addr;
      r_frm_data  <= r_pend_data;
    end
  end

  assign w_frm_write = r_frm_cmd & ~r_frm_read;
  assign w_tag       = {1'b1, r_frm_cmd, w_frm_write, 2'b11, 11'd0};
  assign w_slot1     = r_frm_cmd ? {r_frm_read, r_frm_addr, 12'd0} : 20'd0;
  assign w_slot2     = w_frm_write ? {r_frm_data, 4'd0} : 20'd0;
  assign w_frame     = {w_tag, w_slot1, w_slot2, r_frm_left, r_frm_right};

  // Outputs are computed for the bit the counter is about to enter.
  assign w_idx  = C_DATA_MSB - w_cnt_next[6:0];
  assign w_bit  = (w_cnt_next <= C_B_DATA_END) ? w_frame[w_idx] : 1'b0;
  assign w_sync = (w_cnt_next == C_B_LATCH) || (w_cnt_next <= C_B_SYNC_END);

  always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_SYNC      <= 1'b0;
      O_SDATA_OUT <= 1'b0;
      O_STROBE    <= 1'b0;
      O_CMD_READY <= 1'b1;
    end else begin
      O_SYNC      <= w_sync;
      O_SDATA_OUT <= w_bit;
      O_STROBE    <= (w_cnt_next == C_B_STROBE);
      O_CMD_READY <= ~w_pending_next;
    end
  end

endmodule
`default_nettype wire
